// File: rtl/dm_4k.sv
`default_nettype none
// ============================================================================
//  Module      : dm_4k
//  Description : 4 KiB byte-addressed data memory, 1024 x 32-bit words, with
//                byte/word stores, sign/zero-extended byte loads and
//                asynchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_4k (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sb,
   input  logic        lb,
   input  logic        lbu,
   input  logic [11:0] addr,
   input  logic [31:0] din,
   input  logic        MemWr,
   output logic [31:0] dout
);

   localparam int c_depth = 1024;

   logic [31:0] r_mem [0:c_depth-1];

   logic [9:0]  w_idx;
   logic [1:0]  w_lane;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_word;
   logic [7:0]  w_byte;

   assign w_idx  = addr[11:2];
   assign w_lane = addr[1:0];

   // A byte store replicates din[7:0] on every lane; the lane enable picks one.
   assign w_wdata = sb ? {4{din[7:0]}} : din;

   always_comb begin
      w_be = 4'b0000;
      if (MemWr) begin
         if (sb) begin
            w_be[w_lane] = 1'b1;
         end else begin
            w_be = 4'b1111;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < c_depth; gi++) begin : g_word
         logic w_sel;
         assign w_sel = (w_idx == gi[9:0]);

         for (genvar gb = 0; gb < 4; gb++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_mem[gi][8*gb +: 8] <= 8'h00;
               end else if (w_sel && w_be[gb]) begin
                  r_mem[gi][8*gb +: 8] <= w_wdata[8*gb +: 8];
               end
            end
         end
      end
   endgenerate

   assign w_word = r_mem[w_idx];

   always_comb begin
      w_byte = 8'h00;
      case (w_lane)
         2'd0:    w_byte = w_word[7:0];
         2'd1:    w_byte = w_word[15:8];
         2'd2:    w_byte = w_word[23:16];
         default: w_byte = w_word[31:24];
      endcase
   end

   // lb wins over lbu; output is forced to zero while reset is held.
   always_comb begin
      dout = 32'h0000_0000;
      if (rst_n) begin
         if (lb) begin
            dout = {{24{w_byte[7]}}, w_byte};
         end else if (lbu) begin
            dout = {24'h00_0000, w_byte};
         end else begin
            dout = w_word;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dm_4k.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_4k
//  Description : Self-checking bench for dm_4k against an array-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_4k;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sb, lb, lbu, MemWr;
   logic [11:0] addr;
   logic [31:0] din;
   logic [31:0] dout;

   int checks   = 0;
   int failures = 0;

   int unsigned model [0:1023];

   dm_4k dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb),
      .lb    (lb),
      .lbu   (lbu),
      .addr  (addr),
      .din   (din),
      .MemWr (MemWr),
      .dout  (dout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_read(input logic [11:0] a, input logic l_b, input logic l_bu);
      int unsigned w, b;
      w = model[a / 4];
      b = (w >> (8 * (a % 4))) % 256;
      if (l_b)
         return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      else if (l_bu)
         return b;
      return w;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 1024; i++) model[i] = 0;
   endtask

   task automatic model_write(input logic bsel, input logic [11:0] a, input logic [31:0] d);
      int unsigned sh, keep;
      if (bsel) begin
         sh   = 8 * (a % 4);
         keep = model[a / 4] & ~(32'hFF << sh);
         model[a / 4] = keep | ((d % 256) << sh);
      end else begin
         model[a / 4] = d;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic read_check(input string tag, input logic [11:0] a, input logic l_b, input logic l_bu);
      addr = a; lb = l_b; lbu = l_bu;
      #1;
      check(tag, dout, exp_read(a, l_b, l_bu));
   endtask

   // One clock cycle of store/no-store; dout is checked before and after the edge.
   task automatic do_cycle(input string tag, input logic we, input logic bsel,
                           input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      MemWr = we; sb = bsel; addr = a; din = d; lb = 1'b0; lbu = 1'b0;
      #1;
      check({tag, "_pre"}, dout, exp_read(a, 1'b0, 1'b0));
      @(posedge clk);
      if (we) model_write(bsel, a, d);
      #1;
      check({tag, "_post"}, dout, exp_read(a, 1'b0, 1'b0));
      MemWr = 1'b0; sb = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; sb = 1'b0; lb = 1'b0; lbu = 1'b0; MemWr = 1'b0;
      addr = '0; din = '0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      read_check("rst_000", 12'h000, 1'b0, 1'b0);
      read_check("rst_004", 12'h004, 1'b0, 1'b0);
      read_check("rst_ffc", 12'hFFC, 1'b0, 1'b0);

      // Word writes
      do_cycle("w000", 1'b1, 1'b0, 12'h000, 32'h0000_0004);
      do_cycle("w004", 1'b1, 1'b0, 12'h004, 32'h0000_0012);
      read_check("rd000", 12'h000, 1'b0, 1'b0);
      check("rd000_const", dout, 32'h0000_0004);
      read_check("rd004", 12'h004, 1'b0, 1'b0);
      check("rd004_const", dout, 32'h0000_0012);

      // Byte store into lane 3
      do_cycle("w000b", 1'b1, 1'b0, 12'h000, 32'h0030_1046);
      do_cycle("sb003", 1'b1, 1'b1, 12'h003, 32'h0000_00F0);
      read_check("word000", 12'h000, 1'b0, 1'b0);
      check("word000_const", dout, 32'hF030_1046);

      // Byte loads
      read_check("lb000", 12'h000, 1'b1, 1'b0);
      check("lb000_const", dout, 32'h0000_0046);
      read_check("lb003", 12'h003, 1'b1, 1'b0);
      check("lb003_const", dout, 32'hFFFF_FFF0);
      read_check("lbu003", 12'h003, 1'b0, 1'b1);
      check("lbu003_const", dout, 32'h0000_00F0);
      read_check("lb002", 12'h002, 1'b1, 1'b0);
      check("lb002_const", dout, 32'h0000_0030);
      read_check("lblbu003", 12'h003, 1'b1, 1'b1);
      check("lblbu003_const", dout, 32'hFFFF_FFF0);

      // MemWr low blocks writes, with either sb value
      do_cycle("nowr", 1'b0, 1'b0, 12'h004, 32'hDEAD_BEEF);
      do_cycle("nowr_sb", 1'b0, 1'b1, 12'h004, 32'hDEAD_BEEF);
      check("nowr_const", dout, 32'h0000_0012);

      // Top address must not alias onto word 0
      do_cycle("wffc", 1'b1, 1'b0, 12'hFFC, 32'h1234_5678);
      read_check("alias000", 12'h000, 1'b0, 1'b0);

      // Reset asserted mid-cycle with a pending write
      @(negedge clk);
      MemWr = 1'b1; sb = 1'b0; addr = 12'h000; din = 32'hA5A5_A5A5; lb = 1'b0; lbu = 1'b0;
      #2 rst_n = 1'b0;
      model_clear();
      #1 check("rst_mid_word", dout, 32'h0000_0000);
      lb = 1'b1; #1 check("rst_mid_lb", dout, 32'h0000_0000);
      lb = 1'b0; lbu = 1'b1; #1 check("rst_mid_lbu", dout, 32'h0000_0000);
      lbu = 1'b0;
      @(posedge clk);
      #1 check("rst_hold_edge", dout, 32'h0000_0000);
      MemWr = 1'b0;
      #1 rst_n = 1'b1;
      read_check("rst_after_000", 12'h000, 1'b0, 1'b0);
      read_check("rst_after_ffc", 12'hFFC, 1'b0, 1'b0);
      do_cycle("resume", 1'b1, 1'b0, 12'h000, 32'hCAFE_0001);

      // Randomized traffic against the model; a small address pool forces reuse
      for (int i = 0; i < 300; i++) begin
         logic [11:0] a;
         logic [31:0] d;
         logic        we, bs;
         a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'(($urandom_range(0, 15) * 4) + $urandom_range(0, 3));
         d  = $urandom;
         we = ($urandom_range(0, 3) != 0);
         bs = 1'($urandom);
         do_cycle("rnd", we, bs, a, d);
         read_check("rnd_rd", 12'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)),
                    1'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/dm_4k.md
DM_4K -- requirements
Module: dm_4k

Interface
REQ-001 Parameters: none; geometry fixed at 4 KiB = 1024 words x 32 bits, byte-addressed.
REQ-002 clk  input  1  single clock; all writes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sb  input  1  store-byte qualifier for a write; 0 = full-word store.
REQ-005 lb  input  1  load-byte, sign-extended read select.
REQ-006 lbu  input  1  load-byte, zero-extended read select.
REQ-007 addr  input  12  byte address; addr[11:2] = word index, addr[1:0] = byte lane.
REQ-008 din  input  32  write data.
REQ-009 MemWr  input  1  write enable, sampled at rising clk.
REQ-010 dout  output  32  read data, combinational from addr, lb, lbu and array contents.

Function
REQ-011 Storage SHALL be 1024 x 32-bit words, indexed by addr[11:2].
REQ-012 Byte lanes SHALL be little-endian: lane k = bits [8k+7:8k] of the word, with k = addr[1:0].
REQ-013 Rising clk, rst_n high, MemWr=1, sb=0: word[addr[11:2]] <= din; addr[1:0] ignored.
REQ-014 Rising clk, rst_n high, MemWr=1, sb=1: only lane addr[1:0] of word[addr[11:2]] <= din[7:0]; the other three lanes are unchanged.
REQ-015 MemWr=0: no array change, regardless of sb.
REQ-016 Read with lb=0, lbu=0: dout = word[addr[11:2]]; addr[1:0] ignored.
REQ-017 Read with lb=1: dout = selected lane sign-extended to 32 bits (bit 7 replicated into [31:8]).
REQ-018 Read with lbu=1, lb=0: dout = selected lane zero-extended to 32 bits.
REQ-019 lb and lbu both 1: lb SHALL take priority (sign-extend).
REQ-020 Reads SHALL be asynchronous, zero latency: dout reflects a write in the same delta after the writing clk edge.
REQ-021 Read and write of the same address in one cycle: before the edge dout shows old data; after the edge it shows new data (no bypass).
REQ-022 All 12 address bits are valid; no out-of-range condition exists, and addresses do not wrap or alias.
REQ-023 sb, lb and lbu are independent; sb affects writes only, and lb/lbu affect reads only.

Reset
REQ-024 rst_n low SHALL immediately clear all 1024 words to 0x00000000, independent of clk.
REQ-025 While rst_n is low, writes are blocked even with MemWr=1, and dout = 0x00000000 for every read mode.
REQ-026 When rst_n is deasserted, normal writes resume on the first rising clk edge with rst_n high.
REQ-027 Reset asserted mid-operation SHALL discard any pending write; no partial update survives.

Verification
REQ-028 Reset pulse, then read addr 0x000, 0x004 and 0xFFC in word mode -> dout = 0x00000000 each.
REQ-029 Word write 0x00000004 @0x000, then 0x00000012 @0x004 -> word reads return 0x00000004 and 0x00000012.
REQ-030 Word write 0x00301046 @0x000, then sb=1 din=0x000000F0 @0x003 -> word read @0x000 = 0xF0301046.
REQ-031 With the REQ-030 contents:
- lb @0x000 -> 0x00000046
- lb @0x003 -> 0xFFFFFFF0
- lbu @0x003 -> 0x000000F0
- lb @0x002 -> 0x00000030
- lb=lbu=1 @0x003 -> 0xFFFFFFF0
REQ-032 MemWr=0 with din=0xDEADBEEF @0x004 -> contents unchanged; word read @0x004 = 0x00000012.
REQ-033 Drive rst_n low between clk edges while MemWr=1 -> dout = 0 at once, the word @0x000 stays 0 after the next edge, and writes resume once rst_n is high.
